// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receive path.
// Optional build macro (used by morse_decoder): MORSE_DEBOUNCE_EN.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

    localparam logic       ELEM_DOT    = 1'b0;
    localparam logic       ELEM_DASH   = 1'b1;

    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Longest code that is still accumulated; one more element marks the letter overlong.
    localparam logic [2:0] MAX_ELEMS   = 3'd6;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code to ASCII lookup.
// Code layout: first element in bit len-1, last element in bit 0, dash = 1.
// Bits above len-1 are always zero, so {len, code} is matched exactly.
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] len,
    input  logic [5:0] code,
    output logic [7:0] ascii
);

    // Table lookup; anything not A-Z / 0-9 decodes as '?'.
    always_comb begin
        ascii = ASCII_QMARK;
        case ({len, code})
            {3'd2, 6'b000001}: ascii = 8'h41; // A .-
            {3'd4, 6'b001000}: ascii = 8'h42; // B -...
            {3'd4, 6'b001010}: ascii = 8'h43; // C -.-.
            {3'd3, 6'b000100}: ascii = 8'h44; // D -..
            {3'd1, 6'b000000}: ascii = 8'h45; // E .
            {3'd4, 6'b000010}: ascii = 8'h46; // F ..-.
            {3'd3, 6'b000110}: ascii = 8'h47; // G --.
            {3'd4, 6'b000000}: ascii = 8'h48; // H ....
            {3'd2, 6'b000000}: ascii = 8'h49; // I ..
            {3'd4, 6'b000111}: ascii = 8'h4A; // J .---
            {3'd3, 6'b000101}: ascii = 8'h4B; // K -.-
            {3'd4, 6'b000100}: ascii = 8'h4C; // L .-..
            {3'd2, 6'b000011}: ascii = 8'h4D; // M --
            {3'd2, 6'b000010}: ascii = 8'h4E; // N -.
            {3'd3, 6'b000111}: ascii = 8'h4F; // O ---
            {3'd4, 6'b000110}: ascii = 8'h50; // P .--.
            {3'd4, 6'b001101}: ascii = 8'h51; // Q --.-
            {3'd3, 6'b000010}: ascii = 8'h52; // R .-.
            {3'd3, 6'b000000}: ascii = 8'h53; // S ...
            {3'd1, 6'b000001}: ascii = 8'h54; // T -
            {3'd3, 6'b000001}: ascii = 8'h55; // U ..-
            {3'd4, 6'b000001}: ascii = 8'h56; // V ...-
            {3'd3, 6'b000011}: ascii = 8'h57; // W .--
            {3'd4, 6'b001001}: ascii = 8'h58; // X -..-
            {3'd4, 6'b001011}: ascii = 8'h59; // Y -.--
            {3'd4, 6'b001100}: ascii = 8'h5A; // Z --..
            {3'd5, 6'b011111}: ascii = 8'h30; // 0 -----
            {3'd5, 6'b001111}: ascii = 8'h31; // 1 .----
            {3'd5, 6'b000111}: ascii = 8'h32; // 2 ..---
            {3'd5, 6'b000011}: ascii = 8'h33; // 3 ...--
            {3'd5, 6'b000001}: ascii = 8'h34; // 4 ....-
            {3'd5, 6'b000000}: ascii = 8'h35; // 5 .....
            {3'd5, 6'b010000}: ascii = 8'h36; // 6 -....
            {3'd5, 6'b011000}: ascii = 8'h37; // 7 --...
            {3'd5, 6'b011100}: ascii = 8'h38; // 8 ---..
            {3'd5, 6'b011110}: ascii = 8'h39; // 9 ----.
            default:           ascii = ASCII_QMARK;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: synchronizes a keyed line, times marks/spaces, decodes
// letters to ASCII and presents them on a valid/ready holding register.
// Optional build macro: MORSE_DEBOUNCE_EN adds a glitch filter after the
// synchronizer (level must be stable GLITCH_CYCLES cycles to be accepted).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line quiet, no letter in progress
// ST_MARK  | line high, timing the current element
// ST_SPACE | line low after an element; letter end at 2 units, word end at 5
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int CNT_W       = 27
`ifdef MORSE_DEBOUNCE_EN
    ,
    parameter int GLITCH_CYCLES = UNIT_CYCLES / 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LETTER_CNT = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_CNT   = CNT_W'(5 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]       sync_q;
    logic             key_s;
    logic             key_line;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       code;
    logic [2:0]       len;
    logic             overlong;
    logic             word_pending;

    logic             mark_end;
    logic             letter_end;
    logic             word_end;
    logic             elem;
    logic             emit;
    logic [7:0]       emit_char;
    logic [7:0]       lut_char;

    // Two-flop synchronizer for the asynchronous key line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    assign key_s = sync_q[1];

`ifdef MORSE_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] GLITCH_LAST =
        (GLITCH_CYCLES > 0) ? CNT_W'(GLITCH_CYCLES - 1) : '0;

    logic             key_f;
    logic [CNT_W-1:0] glitch_cnt;

    // Accept a new level only after it has been held for GLITCH_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_f      <= 1'b0;
            glitch_cnt <= '0;
        end else if (key_s == key_f) begin
            glitch_cnt <= '0;
        end else if (glitch_cnt >= GLITCH_LAST) begin
            key_f      <= key_s;
            glitch_cnt <= '0;
        end else begin
            glitch_cnt <= glitch_cnt + CNT_W'(1);
        end
    end

    assign key_line = key_f;
`else
    assign key_line = key_s;
`endif

    // Next-state decode plus element / letter / word event strobes.
    always_comb begin
        state_next = state;
        mark_end   = 1'b0;
        letter_end = 1'b0;
        word_end   = 1'b0;
        elem       = ELEM_DOT;
        emit       = 1'b0;
        emit_char  = ASCII_SPACE;
        case (state)
            ST_IDLE: begin
                if (key_line) state_next = ST_MARK;
            end
            ST_MARK: begin
                if (!key_line) begin
                    mark_end   = 1'b1;
                    elem       = (cnt >= LETTER_CNT) ? ELEM_DASH : ELEM_DOT;
                    state_next = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (cnt == LETTER_CNT) begin
                    letter_end = 1'b1;
                    emit       = 1'b1;
                    emit_char  = overlong ? ASCII_QMARK : lut_char;
                end
                if (cnt == WORD_CNT) begin
                    word_end   = 1'b1;
                    emit       = word_pending;
                    emit_char  = ASCII_SPACE;
                    state_next = ST_IDLE;
                end
                // A new mark always wins, whether or not the letter has ended.
                if (key_line) state_next = ST_MARK;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and duration counter (restarts at 1 on every state change).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Element accumulation; cleared at each letter end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            code         <= '0;
            len          <= '0;
            overlong     <= 1'b0;
            word_pending <= 1'b0;
        end else begin
            if (mark_end) begin
                if (len == MAX_ELEMS) begin
                    overlong <= 1'b1;
                end else begin
                    code <= {code[4:0], elem};
                    len  <= len + 3'd1;
                end
            end else if (letter_end) begin
                code         <= '0;
                len          <= '0;
                overlong     <= 1'b0;
                word_pending <= 1'b1;
            end
            if (word_end) word_pending <= 1'b0;
        end
    end

    morse_lut u_lut (
        .len   (len),
        .code  (code),
        .ascii (lut_char)
    );

    // Holding register: a new character is dropped (overrun) if the old one is still unconsumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            char_data  <= 8'h00;
            char_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (emit) begin
                if (!char_valid || char_ready) begin
                    char_data  <= emit_char;
                    char_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (char_valid && char_ready) begin
                char_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with UNIT_CYCLES=5.
// Build with MORSE_DEBOUNCE_EN defined to exercise the glitch filter (GLITCH_CYCLES=2).
module tb_morse_decoder;

    localparam int UNIT = 5;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       key_in     = 1'b0;
    logic       char_ready = 1'b1;
    logic [7:0] char_data;
    logic       char_valid;
    logic       overrun;
    logic       busy;

    int         checks  = 0;
    int         errors  = 0;
    int         ovr_cnt = 0;
    logic [7:0] rx[$];

    morse_decoder #(
        .UNIT_CYCLES (UNIT),
        .CNT_W       (8)
`ifdef MORSE_DEBOUNCE_EN
        ,
        .GLITCH_CYCLES (2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Record every accepted character and every overrun pulse.
    always @(negedge clk) begin
        if (rst && char_valid && char_ready) rx.push_back(char_data);
        if (rst && overrun) ovr_cnt++;
    end

    task automatic gap(input int n);
        key_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic mark(input int n);
        key_in = 1'b1;
        repeat (n) @(negedge clk);
        key_in = 1'b0;
    endtask

    task automatic send(input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            if (i > 0) gap(UNIT);
            mark((pat[i] == "-") ? 3 * UNIT : UNIT);
        end
    endtask

    task automatic clear_rx();
        rx.delete();
        ovr_cnt = 0;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", char_valid); end
        checks++; if (char_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", char_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sos();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_rx();
        send("...");  gap(3 * UNIT);
        send("---");  gap(3 * UNIT);
        send("...");  gap(35);
        exp = '{8'h53, 8'h4F, 8'h53, 8'h20};
        checks++; if (rx.size() !== exp.size()) begin errors++; $display("FAIL sos_count: got %0d expected %0d", rx.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < rx.size()) ? rx[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL sos_char[%0d]: got %h expected %h", i, got, exp[i]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sos_busy: got %b expected 0", busy); end
    endtask

    task automatic test_threshold();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_rx();
        mark(9);  gap(35);                         // dot -> E
        mark(10); gap(35);                         // dash -> T
        mark(UNIT); gap(9);  mark(UNIT); gap(35);  // same letter -> I
        mark(UNIT); gap(10); mark(UNIT); gap(35);  // letter end -> E E
        exp = '{8'h45, 8'h20, 8'h54, 8'h20, 8'h49, 8'h20, 8'h45, 8'h45, 8'h20};
        checks++; if (rx.size() !== exp.size()) begin errors++; $display("FAIL thr_count: got %0d expected %0d", rx.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < rx.size()) ? rx[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL thr_char[%0d]: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_invalid();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_rx();
        send("......");  gap(35);
        send("......."); gap(3 * UNIT);
        send(".");       gap(35);
        exp = '{8'h3F, 8'h20, 8'h3F, 8'h45, 8'h20};
        checks++; if (rx.size() !== exp.size()) begin errors++; $display("FAIL inv_count: got %0d expected %0d", rx.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < rx.size()) ? rx[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL inv_char[%0d]: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_rx();
        char_ready = 1'b0;
        send("."); gap(3 * UNIT);
        send("-"); gap(18);
        checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", char_valid); end
        checks++; if (char_data !== 8'h45) begin errors++; $display("FAIL bp_data: got %h expected 45", char_data); end
        checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL bp_overrun: got %0d pulses expected 1", ovr_cnt); end
        char_ready = 1'b1;
        gap(20);
        exp = '{8'h45, 8'h20};
        checks++; if (rx.size() !== exp.size()) begin errors++; $display("FAIL bp_count: got %0d expected %0d", rx.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < rx.size()) ? rx[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL bp_char[%0d]: got %h expected %h", i, got, exp[i]); end
        end
        checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL bp_overrun_end: got %0d pulses expected 1", ovr_cnt); end
    endtask

    task automatic test_reset_mid_mark();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_rx();
        send("."); gap(UNIT);
        key_in = 1'b1;
        repeat (3 * UNIT - 1) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        key_in = 1'b0;
        gap(35);
        checks++; if (rx.size() !== 0) begin errors++; $display("FAIL rmm_none: got %0d chars expected 0", rx.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmm_busy: got %b expected 0", busy); end
        send("-."); gap(35);
        exp = '{8'h4E, 8'h20};
        checks++; if (rx.size() !== exp.size()) begin errors++; $display("FAIL rmm_count: got %0d expected %0d", rx.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < rx.size()) ? rx[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL rmm_char[%0d]: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_rx();
`ifdef MORSE_DEBOUNCE_EN
        repeat (3) begin mark(1); gap(4); end
        gap(35);
        checks++; if (rx.size() !== 0) begin errors++; $display("FAIL glitch_none: got %0d chars expected 0", rx.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        mark(UNIT); gap(35);
`else
        mark(1); gap(35);
`endif
        exp = '{8'h45, 8'h20};
        checks++; if (rx.size() !== exp.size()) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", rx.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < rx.size()) ? rx[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL glitch_char[%0d]: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_sos();
        test_threshold();
        test_invalid();
        test_backpressure();
        test_reset_mid_mark();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
